// File: rtl/ram_1w1r_arbiter.sv
// Two-client front end for a 1-write/1-read RAM: independent round-robin
// arbiters for the read and write ports, with a registered read response per client.
module ram_1w1r_arbiter #(
    parameter int W       = 32,
    parameter int ENTRIES = 16,
    parameter int ADDR_SZ = $clog2(ENTRIES)
) (
    input  logic               clk,
    input  logic               reset_p,

    input  logic               a_rd_val,
    output logic               a_rd_rdy,
    input  logic [ADDR_SZ-1:0] a_rd_addr,
    output logic               a_rsp_val,
    output logic [W-1:0]       a_rsp_data,
    input  logic               a_wr_val,
    output logic               a_wr_rdy,
    input  logic [ADDR_SZ-1:0] a_wr_addr,
    input  logic [W-1:0]       a_wr_data,

    input  logic               b_rd_val,
    output logic               b_rd_rdy,
    input  logic [ADDR_SZ-1:0] b_rd_addr,
    output logic               b_rsp_val,
    output logic [W-1:0]       b_rsp_data,
    input  logic               b_wr_val,
    output logic               b_wr_rdy,
    input  logic [ADDR_SZ-1:0] b_wr_addr,
    input  logic [W-1:0]       b_wr_data,

    output logic [ADDR_SZ-1:0] ram_raddr,
    input  logic [W-1:0]       ram_rdata,
    output logic               ram_wen,
    output logic [ADDR_SZ-1:0] ram_waddr,
    output logic [W-1:0]       ram_wdata
);

    // Priority registers: 0 names client A, 1 names client B.
    logic rd_prio_q, rd_prio_d;
    logic wr_prio_q, wr_prio_d;

    logic rd_gnt_a, rd_gnt_b;
    logic wr_gnt_a, wr_gnt_b;

    logic         a_rsp_val_q, b_rsp_val_q;
    logic [W-1:0] a_rsp_data_q, b_rsp_data_q;

    // Grants: a lone requester always wins; on contention the priority decides.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        rd_gnt_a = 1'b0;
        rd_gnt_b = 1'b0;
        wr_gnt_a = 1'b0;
        wr_gnt_b = 1'b0;
        if (!reset_p) begin
            if (a_rd_val && (!b_rd_val || !rd_prio_q)) rd_gnt_a = 1'b1;
            else if (b_rd_val)                         rd_gnt_b = 1'b1;
            if (a_wr_val && (!b_wr_val || !wr_prio_q)) wr_gnt_a = 1'b1;
            else if (b_wr_val)                         wr_gnt_b = 1'b1;
        end
    end

    // After a fire the client that was not granted takes priority; otherwise hold.
    always_comb begin
        rd_prio_d = rd_prio_q;
        wr_prio_d = wr_prio_q;
        if (rd_gnt_a)      rd_prio_d = 1'b1;
        else if (rd_gnt_b) rd_prio_d = 1'b0;
        if (wr_gnt_a)      wr_prio_d = 1'b1;
        else if (wr_gnt_b) wr_prio_d = 1'b0;
    end

    assign a_rd_rdy = rd_gnt_a;
    assign b_rd_rdy = rd_gnt_b;
    assign a_wr_rdy = wr_gnt_a;
    assign b_wr_rdy = wr_gnt_b;

    assign ram_raddr = rd_gnt_a ? a_rd_addr : (rd_gnt_b ? b_rd_addr : '0);
    assign ram_wen   = wr_gnt_a | wr_gnt_b;
    assign ram_waddr = wr_gnt_a ? a_wr_addr : (wr_gnt_b ? b_wr_addr : '0);
    assign ram_wdata = wr_gnt_a ? a_wr_data : (wr_gnt_b ? b_wr_data : '0);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_p) begin
            rd_prio_q    <= 1'b0;
            wr_prio_q    <= 1'b0;
            a_rsp_val_q  <= 1'b0;
            b_rsp_val_q  <= 1'b0;
            a_rsp_data_q <= '0;
            b_rsp_data_q <= '0;
        end else begin
            rd_prio_q   <= rd_prio_d;
            wr_prio_q   <= wr_prio_d;
            a_rsp_val_q <= rd_gnt_a;
            b_rsp_val_q <= rd_gnt_b;
            if (rd_gnt_a) a_rsp_data_q <= ram_rdata;
            if (rd_gnt_b) b_rsp_data_q <= ram_rdata;
        end
    end

    // A response due in a cycle where reset is asserted is squashed.
    assign a_rsp_val  = a_rsp_val_q & ~reset_p;
    assign b_rsp_val  = b_rsp_val_q & ~reset_p;
    assign a_rsp_data = a_rsp_data_q;
    assign b_rsp_data = b_rsp_data_q;

endmodule

// File: tb/tb_ram_1w1r_arbiter.sv
// Scoreboard bench for ram_1w1r_arbiter: directed scenarios then random traffic,
// checked against an abstract model of the shared memory and the two arbiters.
module tb_ram_1w1r_arbiter;

    localparam int W  = 32;
    localparam int AW = 4;
    localparam int N  = 16;

    typedef struct packed {
        logic          rst;
        logic          a_rv;
        logic [AW-1:0] a_ra;
        logic          b_rv;
        logic [AW-1:0] b_ra;
        logic          a_wv;
        logic [AW-1:0] a_wa;
        logic [W-1:0]  a_wd;
        logic          b_wv;
        logic [AW-1:0] b_wa;
        logic [W-1:0]  b_wd;
    } stim_t;

    logic          clk = 1'b0;
    logic          reset_p = 1'b1;
    logic          a_rd_val = 1'b0, b_rd_val = 1'b0, a_wr_val = 1'b0, b_wr_val = 1'b0;
    logic [AW-1:0] a_rd_addr = '0, b_rd_addr = '0, a_wr_addr = '0, b_wr_addr = '0;
    logic [W-1:0]  a_wr_data = '0, b_wr_data = '0;
    logic          a_rd_rdy, b_rd_rdy, a_wr_rdy, b_wr_rdy;
    logic          a_rsp_val, b_rsp_val;
    logic [W-1:0]  a_rsp_data, b_rsp_data;
    logic [AW-1:0] ram_raddr, ram_waddr;
    logic [W-1:0]  ram_rdata, ram_wdata;
    logic          ram_wen;

    int n_tests = 0;
    int n_fail  = 0;

    // Environment RAM seen by the DUT.
    logic [W-1:0] ram_mem [N];
    assign ram_rdata = ram_mem[ram_raddr];
    always @(posedge clk) if (ram_wen) ram_mem[ram_waddr] <= ram_wdata;

    // Reference model state.
    logic [W-1:0] model_mem [N];
    logic         m_rprio = 1'b0;
    logic         m_wprio = 1'b0;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic         prev_rst = 1'b1;

    always #5 clk = ~clk;

    ram_1w1r_arbiter #(.W(W), .ENTRIES(N), .ADDR_SZ(AW)) dut (
        .clk(clk), .reset_p(reset_p),
        .a_rd_val(a_rd_val), .a_rd_rdy(a_rd_rdy), .a_rd_addr(a_rd_addr),
        .a_rsp_val(a_rsp_val), .a_rsp_data(a_rsp_data),
        .a_wr_val(a_wr_val), .a_wr_rdy(a_wr_rdy), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data),
        .b_rd_val(b_rd_val), .b_rd_rdy(b_rd_rdy), .b_rd_addr(b_rd_addr),
        .b_rsp_val(b_rsp_val), .b_rsp_data(b_rsp_data),
        .b_wr_val(b_wr_val), .b_wr_rdy(b_wr_rdy), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .ram_wen(ram_wen),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata)
    );

    task automatic check(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // 0 = nobody, 1 = A, 2 = B.
    function automatic int winner(input logic av, input logic bv, input logic prio);
        if (av && bv) return prio ? 2 : 1;
        if (av) return 1;
        if (bv) return 2;
        return 0;
    endfunction

    // One clock cycle: drive after the edge, check combinational outputs mid-cycle.
    task automatic step(input stim_t s);
        int rg, wg;
        logic [AW-1:0] exp_raddr, exp_waddr;
        logic [W-1:0]  exp_wdata;
        @(posedge clk);
        #1;
        reset_p   = s.rst;
        a_rd_val  = s.a_rv; a_rd_addr = s.a_ra;
        b_rd_val  = s.b_rv; b_rd_addr = s.b_ra;
        a_wr_val  = s.a_wv; a_wr_addr = s.a_wa; a_wr_data = s.a_wd;
        b_wr_val  = s.b_wv; b_wr_addr = s.b_wa; b_wr_data = s.b_wd;
        if (s.rst) begin
            qa.delete();
            qb.delete();
        end
        #3;
        if (prev_rst && !s.rst) begin
            check("a_rsp_data_after_reset", a_rsp_data, '0);
            check("b_rsp_data_after_reset", b_rsp_data, '0);
        end
        prev_rst = s.rst;
        rg = s.rst ? 0 : winner(s.a_rv, s.b_rv, m_rprio);
        wg = s.rst ? 0 : winner(s.a_wv, s.b_wv, m_wprio);
        exp_raddr = (rg == 1) ? s.a_ra : (rg == 2) ? s.b_ra : '0;
        exp_waddr = (wg == 1) ? s.a_wa : (wg == 2) ? s.b_wa : '0;
        exp_wdata = (wg == 1) ? s.a_wd : (wg == 2) ? s.b_wd : '0;
        check("a_rd_rdy", a_rd_rdy, rg == 1);
        check("b_rd_rdy", b_rd_rdy, rg == 2);
        check("a_wr_rdy", a_wr_rdy, wg == 1);
        check("b_wr_rdy", b_wr_rdy, wg == 2);
        check("ram_raddr", ram_raddr, exp_raddr);
        check("ram_wen", ram_wen, wg != 0);
        check("ram_waddr", ram_waddr, exp_waddr);
        check("ram_wdata", ram_wdata, exp_wdata);
        // Reads see the memory as it was before this cycle's write.
        if (rg == 1) qa.push_back(model_mem[s.a_ra]);
        if (rg == 2) qb.push_back(model_mem[s.b_ra]);
        if (wg != 0) model_mem[exp_waddr] = exp_wdata;
        if (s.rst) begin
            m_rprio = 1'b0;
            m_wprio = 1'b0;
        end else begin
            if (rg != 0) m_rprio = (rg == 1);
            if (wg != 0) m_wprio = (wg == 1);
        end
    endtask

    // Response monitor: a fire in cycle k must be answered in cycle k+1 and only then.
    always @(posedge clk) begin
        logic exp_a, exp_b;
        #2;
        exp_a = qa.size() > 0;
        exp_b = qb.size() > 0;
        check("a_rsp_val", a_rsp_val, exp_a);
        check("b_rsp_val", b_rsp_val, exp_b);
        if (exp_a) begin
            if (a_rsp_val) check("a_rsp_data", a_rsp_data, qa.pop_front());
            else void'(qa.pop_front());
        end
        if (exp_b) begin
            if (b_rsp_val) check("b_rsp_data", b_rsp_data, qb.pop_front());
            else void'(qb.pop_front());
        end
    end

    initial begin
        stim_t s;
        for (int i = 0; i < N; i++) begin
            ram_mem[i]   = $urandom;
            model_mem[i] = ram_mem[i];
        end

        // Reset for two cycles, then idle.
        s = '0; s.rst = 1'b1;
        step(s); step(s);
        s = '0;
        step(s);

        // A writes 3 <- 0x5, then reads it back.
        s = '0; s.a_wv = 1'b1; s.a_wa = 4'd3; s.a_wd = 32'h5;
        step(s);
        s = '0; s.a_rv = 1'b1; s.a_ra = 4'd3;
        step(s);
        s = '0; step(s);

        // Contending writers alternate.
        s = '0; s.a_wv = 1'b1; s.a_wa = 4'd1; s.a_wd = 32'hA;
        s.b_wv = 1'b1; s.b_wa = 4'd2; s.b_wd = 32'hB;
        repeat (4) step(s);
        s = '0; step(s);

        // Contending readers alternate, each getting its own data.
        s = '0; s.a_rv = 1'b1; s.a_ra = 4'd1; s.b_rv = 1'b1; s.b_ra = 4'd2;
        repeat (4) step(s);
        s = '0; step(s);

        // Same-cycle read and write to one address returns the old data.
        s = '0; s.a_wv = 1'b1; s.a_wa = 4'd7; s.a_wd = 32'h1;
        step(s);
        s = '0; s.a_wv = 1'b1; s.a_wa = 4'd7; s.a_wd = 32'h2; s.b_rv = 1'b1; s.b_ra = 4'd7;
        step(s);
        s = '0; s.b_rv = 1'b1; s.b_ra = 4'd7;
        step(s);
        s = '0; step(s);

        // Read fires, then reset arrives together with a pending write.
        s = '0; s.a_rv = 1'b1; s.a_ra = 4'd3;
        step(s);
        s = '0; s.rst = 1'b1; s.a_wv = 1'b1; s.a_wa = 4'd9; s.a_wd = 32'hDEAD;
        step(s);
        s = '0; s.rst = 1'b1;
        step(s);
        s = '0; step(s);

        // Random traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            s.rst  = ($urandom_range(0, 59) == 0);
            s.a_rv = ($urandom_range(0, 9) < 6);
            s.b_rv = ($urandom_range(0, 9) < 6);
            s.a_wv = ($urandom_range(0, 9) < 6);
            s.b_wv = ($urandom_range(0, 9) < 6);
            s.a_ra = 4'($urandom_range(0, N - 1));
            s.b_ra = 4'($urandom_range(0, N - 1));
            s.a_wa = 4'($urandom_range(0, N - 1));
            s.b_wa = 4'($urandom_range(0, N - 1));
            s.a_wd = $urandom;
            s.b_wd = $urandom;
            step(s);
        end

        s = '0;
        repeat (3) step(s);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
